// File: rtl/gate_sweep_ctrl.sv
// Exhaustive 3-input gate sweep sequencer: drives vectors 0..7, dwells, samples d/e.
// Optional macro GATE_SWEEP_CHECK_EN compiles in the response comparison and error count.
module gate_sweep_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] exp_d,
  input  logic [7:0] exp_e,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  input  logic       e,
  output logic       busy,
  output logic       done,
  output logic [2:0] vec_idx,
  output logic [3:0] err_cnt,
  output logic       pass
);

  localparam int unsigned NVEC = 8;
  localparam int unsigned IW   = 3;
  localparam int unsigned EW   = 4;
  localparam int unsigned CW   = 8;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_dwell, w_dwell;
  logic [IW-1:0]   r_vec_idx, w_vec_idx;
  logic [EW-1:0]   r_err_cnt, w_err_cnt;
  logic [2:0]      r_abc, w_abc;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_pass, w_pass;
  logic            w_mismatch;

`ifdef GATE_SWEEP_CHECK_EN
  assign w_mismatch = (d != exp_d[r_vec_idx]) || (e != exp_e[r_vec_idx]);
`else
  logic w_unused;
  assign w_mismatch = 1'b0;
  assign w_unused   = ^{exp_d, exp_e, d, e};
`endif

  // State and all outputs are registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_dwell   <= '0;
      r_vec_idx <= '0;
      r_err_cnt <= '0;
      r_abc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_dwell   <= w_dwell;
      r_vec_idx <= w_vec_idx;
      r_err_cnt <= w_err_cnt;
      r_abc     <= w_abc;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_pass    <= w_pass;
    end
  end

  // Next state; defaults describe the parked (IDLE-like) output values
  always_comb begin
    w_state   = r_state;
    w_dwell   = '0;
    w_vec_idx = r_vec_idx;
    w_err_cnt = r_err_cnt;
    w_abc     = 3'b000;
    w_busy    = 1'b0;
    w_done    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state   = DRIVE;
          w_vec_idx = '0;
          w_err_cnt = '0;
          w_busy    = 1'b1;
        end
      end
      DRIVE: begin
        if (abort) begin
          w_state = IDLE;
        end else begin
          w_busy = 1'b1;
          w_abc  = r_vec_idx;
          if (r_dwell == CW'(DWELL - 1)) begin
            w_state = SAMPLE;
          end else begin
            w_dwell = r_dwell + CW'(1);
          end
        end
      end
      SAMPLE: begin
        if (abort) begin
          w_state = IDLE;
        end else begin
          if (w_mismatch) begin
            w_err_cnt = r_err_cnt + EW'(1);
          end
          if (r_vec_idx == IW'(NVEC - 1)) begin
            w_state = DONE;
            w_done  = 1'b1;
          end else begin
            w_state   = DRIVE;
            w_vec_idx = r_vec_idx + IW'(1);
            w_abc     = r_vec_idx + IW'(1);
            w_busy    = 1'b1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          w_state = IDLE;
        end else if (start) begin
          w_state   = DRIVE;
          w_vec_idx = '0;
          w_err_cnt = '0;
          w_busy    = 1'b1;
        end else begin
          w_done = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase

    w_pass = w_done && (w_err_cnt == EW'(0));
  end

  assign a       = r_abc[2];
  assign b       = r_abc[1];
  assign c       = r_abc[0];
  assign busy    = r_busy;
  assign done    = r_done;
  assign vec_idx = r_vec_idx;
  assign err_cnt = r_err_cnt;
  assign pass    = r_pass;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: table of full sweeps plus abort/reset corner sequences.
// Expectations follow the GATE_SWEEP_CHECK_EN build setting.
module tb_gate_sweep_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned PER   = DW + 1;
  localparam int unsigned SWEEP = 8 * PER;
`ifdef GATE_SWEEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] exp_d;
  logic [7:0] exp_e;
  logic       a, b, c;
  logic       d, e;
  logic       busy, done, pass;
  logic [2:0] vec_idx;
  logic [3:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] ed;
    logic [7:0] ee;
    logic [3:0] err;
    logic       pass;
    bit         poke;
  } rec_t;

  rec_t tbl[7];

  gate_sweep_ctrl #(.DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .exp_d(exp_d), .exp_e(exp_e), .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy), .done(done), .vec_idx(vec_idx), .err_cnt(err_cnt), .pass(pass)
  );

  // Logic unit under test: d = OR of inputs, e = NOR of inputs
  always_comb begin
    d = a | b | c;
    e = ~(a | b | c);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_sweep(input logic [7:0] ed, input logic [7:0] ee,
                           input logic [3:0] x_err, input logic x_pass,
                           input bit poke, input string nm);
    logic [2:0] v;
    exp_d = ed;
    exp_e = ee;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < int'(SWEEP); t++) begin
      v = 3'(t / int'(PER));
      chk($sformatf("%s step t=%0d", nm, t), 32'({a, b, c, vec_idx, busy, done}),
          32'({v, v, 1'b1, 1'b0}));
      start = poke && (t % 7 == 3);
      tick();
      start = 1'b0;
    end
    chk({nm, " done"}, 32'({busy, done, a, b, c, vec_idx}), 32'({1'b0, 1'b1, 3'b000, 3'd7}));
    chk({nm, " err_cnt"}, 32'(err_cnt), 32'(x_err));
    chk({nm, " pass"}, 32'(pass), 32'(x_pass));
    tick();
    chk({nm, " held"}, 32'({done, busy, err_cnt, pass}), 32'({1'b1, 1'b0, x_err, x_pass}));
  endtask

  initial begin
    logic [3:0] x_err;
    logic       x_pass;

    tbl[0] = '{ed: 8'hFE, ee: 8'h01, err: 4'd0, pass: 1'b1, poke: 1'b0};
    tbl[1] = '{ed: 8'hFE, ee: 8'h01, err: 4'd0, pass: 1'b1, poke: 1'b1};
    tbl[2] = '{ed: 8'hFF, ee: 8'h01, err: 4'd1, pass: 1'b0, poke: 1'b0};
    tbl[3] = '{ed: 8'hFE, ee: 8'h00, err: 4'd1, pass: 1'b0, poke: 1'b0};
    tbl[4] = '{ed: 8'hFF, ee: 8'h00, err: 4'd1, pass: 1'b0, poke: 1'b1};
    tbl[5] = '{ed: 8'h00, ee: 8'hFF, err: 4'd7, pass: 1'b0, poke: 1'b0};
    tbl[6] = '{ed: 8'h0F, ee: 8'hF0, err: 4'd5, pass: 1'b0, poke: 1'b0};

    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    exp_d = 8'h00;
    exp_e = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("reset async", 32'({a, b, c, busy, done, pass, vec_idx, err_cnt}), 32'(0));
    tick();
    tick();
    chk("reset held", 32'({a, b, c, busy, done, pass, vec_idx, err_cnt}), 32'(0));
    #3 rst_n = 1'b1;

    // First start right after reset release, then the table of sweeps back to back
    for (int i = 0; i < 7; i++) begin
      x_err  = CHK ? tbl[i].err : 4'd0;
      x_pass = CHK ? tbl[i].pass : 1'b1;
      run_sweep(tbl[i].ed, tbl[i].ee, x_err, x_pass, tbl[i].poke, $sformatf("sweep%0d", i));
    end

    // Scenario 6 style: all expectations wrong
    x_err = CHK ? 4'd8 : 4'd0;
    run_sweep(8'h01, 8'hFE, x_err, !CHK, 1'b0, "allbad");

    // start+abort together in DONE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("done abort wins", 32'({busy, done, pass, a, b, c}), 32'(0));
    chk("done abort err held", 32'(err_cnt), 32'(x_err));

    // start+abort together in IDLE: no sweep
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    chk("idle start+abort", 32'({busy, done, a, b, c}), 32'(0));

    // Abort during DRIVE of vector 3
    exp_d = 8'h01;
    exp_e = 8'hFE;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("pre-abort vec3", 32'({vec_idx, busy, a, b, c}), 32'({3'd3, 1'b1, 3'd3}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort drive", 32'({busy, done, pass, a, b, c}), 32'(0));
    chk("abort drive err held", 32'(err_cnt), 32'(CHK ? 3 : 0));
    repeat (SWEEP) tick();
    chk("abort stays idle", 32'({busy, done, err_cnt}), 32'({1'b0, 1'b0, CHK ? 4'd3 : 4'd0}));
    run_sweep(8'hFE, 8'h01, 4'd0, 1'b1, 1'b0, "after_abort");

    // Abort during SAMPLE of vector 1 skips that vector's comparison
    exp_d = 8'h01;
    exp_e = 8'hFE;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (PER + DW) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort sample", 32'({busy, done, a, b, c}), 32'(0));
    chk("abort sample err", 32'(err_cnt), 32'(CHK ? 1 : 0));

    // Asynchronous reset during SAMPLE of vector 5
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5 * PER + DW) tick();
    chk("pre-reset vec5", 32'({vec_idx, busy}), 32'({3'd5, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    chk("reset mid-sweep", 32'({a, b, c, busy, done, pass, vec_idx, err_cnt}), 32'(0));
    tick();
    #3 rst_n = 1'b1;
    repeat (SWEEP) tick();
    chk("no done after reset", 32'({busy, done, pass}), 32'(0));
    run_sweep(8'hFE, 8'h01, 4'd0, 1'b1, 1'b0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter DWELL, default 4, SHALL set the number of cycles each input vector is driven before sampling; legal range is 1..255.
REQ-003 Port clk, input, 1 bit: the single clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: a single-cycle pulse that begins a sweep.
REQ-006 Port abort, input, 1 bit: a single-cycle pulse that terminates a sweep.
REQ-007 Port exp_d, input, 8 bits: expected d for each vector; bit i applies to vector i.
REQ-008 Port exp_e, input, 8 bits: expected e for each vector; bit i applies to vector i.
REQ-009 Ports a, b and c, outputs, 1 bit each: the drive to the logic unit under test; vector = {a,b,c}.
REQ-010 Ports d and e, inputs, 1 bit each: the responses from the logic unit under test.
REQ-011 Port busy, output, 1 bit: high while a sweep is in progress.
REQ-012 Port done, output, 1 bit: a level that is high after a sweep completes.
REQ-013 Port vec_idx, output, 3 bits: the index of the vector currently driven.
REQ-014 Port err_cnt, output, 4 bits: the number of mismatching vectors, range 0..8.
REQ-015 Port pass, output, 1 bit: high when done is high and err_cnt is 0.

Function
REQ-016 The state machine SHALL have the states IDLE, DRIVE, SAMPLE and DONE.
REQ-017 IDLE -> DRIVE on start; vec_idx is cleared to 0, err_cnt is cleared to 0, done is cleared, and busy is set.
REQ-018 In DRIVE the outputs {a,b,c} SHALL equal vec_idx, and a dwell counter SHALL run for exactly DWELL cycles before the transition DRIVE -> SAMPLE.
REQ-019 In SAMPLE, for one cycle, the block SHALL compare d against exp_d[vec_idx] and e against exp_e[vec_idx]; a mismatch on either increments err_cnt by 1, at most once per vector.
REQ-020 SAMPLE -> DRIVE with vec_idx+1 when vec_idx < 7; SAMPLE -> DONE when vec_idx == 7, without wrapping vec_idx.
REQ-021 A full sweep SHALL take exactly 8*(DWELL+1) cycles from the start edge until done rises.
REQ-022 In DONE: busy is 0, done is 1, and {a,b,c} is 3'b000; err_cnt and vec_idx are held.
REQ-023 DONE -> DRIVE on start, which restarts the sweep as in REQ-017; DONE -> IDLE on abort, which clears done.
REQ-024 start SHALL be ignored while in DRIVE or SAMPLE.
REQ-025 abort in DRIVE or SAMPLE SHALL go to IDLE on the next edge: {a,b,c} = 0, busy = 0, done = 0, err_cnt held.
REQ-026 start and abort in the same cycle: abort SHALL win in every state, and from IDLE no sweep starts.
REQ-027 exp_d and exp_e SHALL be sampled only in SAMPLE, so changing them mid-sweep affects only the vectors not yet sampled.
REQ-028 All outputs SHALL be registered; d and e are used directly, with no input synchronizer.

Reset
REQ-029 Assertion of rst_n low SHALL, asynchronously: force the state to IDLE; a, b, c, busy, done and pass to 0; vec_idx to 3'd0; err_cnt to 4'd0; and the dwell counter to 0.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep with no completion indication.
REQ-031 The first start SHALL be honoured on the first rising clk edge after rst_n deasserts.

Configuration
REQ-032 Macro GATE_SWEEP_CHECK_EN, when defined, SHALL compile in the comparison logic and the err_cnt register as specified above.
REQ-033 Without GATE_SWEEP_CHECK_EN, err_cnt SHALL be constant 0, pass SHALL equal done, and exp_d, exp_e, d and e SHALL be unused; sequencing and timing are unchanged.

Verification
REQ-034 Scenario 1: DWELL=4, exp_d=8'hFE, exp_e=8'h01, DUT d=a|b|c and e=~(a|b|c), start pulse -> {a,b,c} steps 0..7, each held for 5 cycles; done rises at cycle 40; err_cnt=0; pass=1.
REQ-035 Scenario 2: same as Scenario 1 but exp_d=8'hFF -> err_cnt=1 (vector 0), pass=0, done=1.
REQ-036 Scenario 3: abort during DRIVE of vector 3 -> next cycle busy=0, {a,b,c}=0, done=0; a later start runs a full sweep from vector 0.
REQ-037 Scenario 4: start pulsed repeatedly mid-sweep, then start and abort together in IDLE -> sweep length unchanged at 40 cycles; no sweep begins from IDLE.
REQ-038 Scenario 5: rst_n pulled low asynchronously during SAMPLE of vector 5 -> all outputs read 0 immediately, with no clk edge needed.
REQ-039 Scenario 6: build without GATE_SWEEP_CHECK_EN and exp_d=8'h00 -> err_cnt=0 and pass=1 at done.
